// File: rtl/disp_pkg.sv
// Shared definitions for the scaled ADC display: FSM states, 7-segment
// glyph lookup and constant-evaluable helper functions.
package disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_BCD,
        ST_DONE
    } state_t;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_D0 = 7'h3F;
    localparam logic [6:0] SEG_D1 = 7'h06;
    localparam logic [6:0] SEG_D2 = 7'h5B;
    localparam logic [6:0] SEG_D3 = 7'h4F;
    localparam logic [6:0] SEG_D4 = 7'h66;
    localparam logic [6:0] SEG_D5 = 7'h6D;
    localparam logic [6:0] SEG_D6 = 7'h7D;
    localparam logic [6:0] SEG_D7 = 7'h07;
    localparam logic [6:0] SEG_D8 = 7'h7F;
    localparam logic [6:0] SEG_D9 = 7'h6F;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned     r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // BCD digit to glyph; codes above 9 never occur and render dark
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_D0;
            4'd1:    return SEG_D1;
            4'd2:    return SEG_D2;
            4'd3:    return SEG_D3;
            4'd4:    return SEG_D4;
            4'd5:    return SEG_D5;
            4'd6:    return SEG_D6;
            4'd7:    return SEG_D7;
            4'd8:    return SEG_D8;
            4'd9:    return SEG_D9;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift per clock.
// Ports: clk/rst; i_start (first iteration, consumes i_bin directly);
// i_bin QW-bit binary; o_busy iterations pending; o_done_c high on the
// edge that performs the final shift; o_bcd 4*DIGITS-bit result.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned QW     = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [QW-1:0]         i_bin,
    output logic                  o_busy,
    output logic                  o_done_c,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = clog2(QW + 1);

    logic [QW-1:0] r_bin;
    logic [BW-1:0] r_bcd;
    logic [CW-1:0] r_cnt;
    logic          r_active;

    logic [QW-1:0] w_src_bin;
    logic [BW-1:0] w_src_bcd;
    logic [BW-1:0] w_adj;
    logic [CW-1:0] w_cnt;
    logic          w_run;

    // Start cycle works on the fresh operand so no load cycle is spent
    always_comb begin
        w_src_bin = i_start ? i_bin : r_bin;
        w_src_bcd = i_start ? '0 : r_bcd;
        w_cnt     = i_start ? '0 : r_cnt;
        w_run     = i_start || r_active;
        w_adj     = '0;
        for (int unsigned n = 0; n < DIGITS; n++) begin
            w_adj[4*n +: 4] = (w_src_bcd[4*n +: 4] >= 4'd5) ? w_src_bcd[4*n +: 4] + 4'd3
                                                             : w_src_bcd[4*n +: 4];
        end
        o_done_c = w_run && (w_cnt == CW'(QW - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (w_run) begin
            r_bcd    <= {w_adj[BW-2:0], w_src_bin[QW-1]};
            r_bin    <= w_src_bin << 1;
            r_cnt    <= w_cnt + CW'(1);
            r_active <= !o_done_c;
        end
    end

    assign o_busy = r_active;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/adc_scaled_display.sv
// ADC code to scaled BCD value with a multiplexed 7-segment driver.
// Ports: clk/rst (async, active-high); sample_in/sample_valid accepted in
// IDLE only; busy while converting; value_bcd + one-cycle bcd_valid on
// update; seg {dp,g..a} and one-hot sel drive the display.
module adc_scaled_display
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned FULL_SCALE     = 5000,
    parameter int unsigned SCAN_DIV       = 20000,
    parameter int unsigned DP_POS         = 3,
    parameter int unsigned BLANK_LZ       = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   value_bcd,
    output logic                  bcd_valid,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel
);

    localparam int unsigned QW          = clog2(FULL_SCALE + 1);
    localparam int unsigned PW          = DATA_W + QW;
    localparam int unsigned BW          = 4 * DIGITS;
    localparam int unsigned CW          = clog2(PW + 1);
    localparam int unsigned SW          = clog2(SCAN_DIV);
    localparam int unsigned IW          = clog2(DIGITS);
    localparam int unsigned BLANK_FLOOR = (DP_POS >= DIGITS) ? 0 : DP_POS;
    localparam logic              INV     = (SEG_ACTIVE_LOW != 0);
    localparam logic [DATA_W:0]   DIVISOR = {1'b0, {DATA_W{1'b1}}};
    localparam logic [7:0]        SEG_RST = {8{INV}};
    localparam logic [DIGITS-1:0] SEL_RST = DIGITS'(1) ^ {DIGITS{INV}};

    if (FULL_SCALE > pow10(DIGITS) - 1) begin : g_bad_full_scale
        $error("FULL_SCALE does not fit in DIGITS decimal digits");
    end
    if (DIGITS < 2) begin : g_bad_digits
        $error("DIGITS must be at least 2");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_sample;
    logic [PW-1:0]       r_prod;
    logic [DATA_W-1:0]   r_rem;
    logic [QW-1:0]       r_quo;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_bcd_valid;
    logic [BW-1:0]       r_value;      // doubles as the display buffer
    logic [SW-1:0]       r_scan_cnt;
    logic [IW-1:0]       r_idx;
    logic [DIGITS-1:0]   r_sel;
    logic [7:0]          r_seg;

    logic [DATA_W:0]     w_rem_sh;
    logic                w_ge;
    logic                w_bcd_start_c;
    logic                w_bcd_busy;
    logic                w_bcd_done_c;
    logic [BW-1:0]       w_bcd;

    // Restoring divide step: one quotient bit per DIV cycle
    assign w_rem_sh = {r_rem, r_prod[PW-1]};
    assign w_ge     = (w_rem_sh >= DIVISOR);

    bin2bcd_seq #(.QW(QW), .DIGITS(DIGITS)) u_bcd (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_bcd_start_c),
        .i_bin    (r_quo),
        .o_busy   (w_bcd_busy),
        .o_done_c (w_bcd_done_c),
        .o_bcd    (w_bcd)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state and converter kick-off
    always_comb begin
        w_state_nxt   = r_state;
        w_bcd_start_c = 1'b0;
        case (r_state)
            ST_IDLE: if (sample_valid) w_state_nxt = ST_MUL;
            ST_MUL:  w_state_nxt = ST_DIV;
            ST_DIV:  if (r_cnt == CW'(PW - 1)) w_state_nxt = ST_BCD;
            ST_BCD: begin
                w_bcd_start_c = !w_bcd_busy;
                if (w_bcd_done_c) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Conversion datapath and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample    <= '0;
            r_prod      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_bcd_valid <= 1'b0;
            r_value     <= '0;
        end else begin
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_bcd_valid <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: if (sample_valid) r_sample <= sample_in;
                ST_MUL: begin
                    r_prod <= PW'(r_sample) * PW'(FULL_SCALE);
                    r_rem  <= '0;
                    r_quo  <= '0;
                    r_cnt  <= '0;
                end
                ST_DIV: begin
                    r_prod <= r_prod << 1;
                    r_rem  <= w_ge ? DATA_W'(w_rem_sh - DIVISOR) : DATA_W'(w_rem_sh);
                    r_quo  <= QW'({r_quo, w_ge});
                    r_cnt  <= r_cnt + CW'(1);
                end
                ST_DONE: r_value <= w_bcd;
                default: ;
            endcase
        end
    end

    logic              w_tick;
    logic [IW-1:0]     w_nxt_idx;
    logic [3:0]        w_digit;
    logic              w_upper_nz;
    logic              w_blank;
    logic [7:0]        w_seg_c;
    logic [DIGITS-1:0] w_sel_c;

    // Glyph for the digit about to be selected; uses the buffer as it
    // stands before this edge, so a coincident load shows next tick
    always_comb begin
        w_tick     = (r_scan_cnt == SW'(SCAN_DIV - 1));
        w_nxt_idx  = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        w_digit    = '0;
        w_upper_nz = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (IW'(k) == w_nxt_idx) w_digit = r_value[4*k +: 4];
            if ((IW'(k) >= w_nxt_idx) && (r_value[4*k +: 4] != 4'd0)) w_upper_nz = 1'b1;
        end
        w_blank = (BLANK_LZ != 0) && (w_nxt_idx > IW'(BLANK_FLOOR)) && !w_upper_nz;
        w_seg_c = w_blank ? 8'h00 : {1'b0, seg7(w_digit)};
        if (32'(w_nxt_idx) == DP_POS) w_seg_c[7] = 1'b1;
        w_seg_c = w_seg_c ^ {8{INV}};
        w_sel_c = (DIGITS'(1) << w_nxt_idx) ^ {DIGITS{INV}};
    end

    // Digit scan: sel and seg update together on the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_sel      <= SEL_RST;
            r_seg      <= SEG_RST;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
            r_idx      <= w_nxt_idx;
            r_sel      <= w_sel_c;
            r_seg      <= w_seg_c;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    assign busy      = r_busy;
    assign bcd_valid = r_bcd_valid;
    assign value_bcd = r_value;
    assign sel       = r_sel;
    assign seg       = r_seg;

endmodule

// File: tb/tb_adc_scaled_display.sv
// Directed bench: four display variants share one sample stream.
module tb_adc_scaled_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;

    logic        busy_m, valid_m, busy_b, valid_b, busy_n, valid_n, busy_i, valid_i;
    logic [15:0] value_m, value_b, value_n, value_i;
    logic [7:0]  seg_m, seg_b, seg_n, seg_i;
    logic [3:0]  sel_m, sel_b, sel_n, sel_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_scaled_display #(.SCAN_DIV(4)) u_main (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy_m), .value_bcd(value_m), .bcd_valid(valid_m), .seg(seg_m), .sel(sel_m));

    adc_scaled_display #(.SCAN_DIV(4), .DP_POS(4), .BLANK_LZ(1)) u_dp4b (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy_b), .value_bcd(value_b), .bcd_valid(valid_b), .seg(seg_b), .sel(sel_b));

    adc_scaled_display #(.SCAN_DIV(4), .DP_POS(4), .BLANK_LZ(0)) u_dp4n (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy_n), .value_bcd(value_n), .bcd_valid(valid_n), .seg(seg_n), .sel(sel_n));

    adc_scaled_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) u_inv (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .busy(busy_i), .value_bcd(value_i), .bcd_valid(valid_i), .seg(seg_i), .sel(sel_i));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample, return cycles from accept edge to bcd_valid
    task automatic send(input logic [7:0] code, output int lat);
        @(negedge clk);
        sample_in    = code;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("busy_after_accept", 32'(busy_m), 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_m && lat < 100);
    endtask

    // Follow four full digit phases; expected glyphs packed {d3,d2,d1,d0}
    task automatic scan_chk(input logic [31:0] e_m, input logic [31:0] e_b, input logic [31:0] e_n);
        logic [3:0] prev, es, esi;
        logic [7:0] em, emi;
        int n, st, idx;
        prev = sel_m;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sel_m == prev && n < 40);
        chk("scan_tick_seen", 32'(n < 40), 32'd1);
        st = 0;
        for (int j = 0; j < 4; j++) if (sel_m[j]) st = j;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            idx = (st + k / 4) % 4;
            es  = 4'(1 << idx);
            esi = ~es;
            em  = e_m[idx*8 +: 8];
            emi = ~em;
            chk("sel_main", 32'(sel_m), 32'(es));
            chk("seg_main", 32'(seg_m), 32'(em));
            chk("sel_inv",  32'(sel_i), 32'(esi));
            chk("seg_inv",  32'(seg_i), 32'(emi));
            chk("seg_dp4_blank",   32'(seg_b), 32'(e_b[idx*8 +: 8]));
            chk("seg_dp4_noblank", 32'(seg_n), 32'(e_n[idx*8 +: 8]));
        end
    endtask

    initial begin
        int lat, pulses, t1, t2, e;
        logic [15:0] last_val;
        rst          = 1'b1;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",      32'(busy_m),  32'd0);
        chk("rst_bcd_valid", 32'(valid_m), 32'd0);
        chk("rst_value",     32'(value_m), 32'd0);
        chk("rst_sel",       32'(sel_m),   32'h1);
        chk("rst_seg",       32'(seg_m),   32'h00);
        chk("rst_sel_inv",   32'(sel_i),   32'hE);
        chk("rst_seg_inv",   32'(seg_i),   32'hFF);
        rst = 1'b0;

        // Full scale: 255*5000/255 = 5000
        send(8'hFF, lat);
        chk("lat_ff",        32'(lat),     32'd36);
        chk("value_ff",      32'(value_m), 32'h5000);
        chk("value_ff_inv",  32'(value_i), 32'h5000);
        chk("busy_in_done",  32'(busy_m),  32'd0);
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(valid_m), 32'd0);
        scan_chk(32'hED3F3F3F, 32'h6D3F3F3F, 32'h6D3F3F3F);

        // 128*5000/255 = 2509.8 -> 2509
        send(8'h80, lat);
        chk("lat_80",   32'(lat),     32'd36);
        chk("value_80", 32'(value_m), 32'h2509);
        chk("value_80_dp4", 32'(value_b), 32'h2509);

        // 5000/255 = 19.6 -> 19; leading zeros at/below DP stay lit
        send(8'h01, lat);
        chk("lat_01",   32'(lat),     32'd36);
        chk("value_01", 32'(value_m), 32'h0019);
        scan_chk(32'hBF3F066F, 32'h0000066F, 32'h3F3F066F);

        // Sample arriving while busy is dropped
        @(negedge clk);
        sample_in    = 8'h80;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        pulses   = 0;
        last_val = 16'h0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                sample_in    = 8'hFF;
                sample_valid = 1'b1;
            end
            if (c == 5) sample_valid = 1'b0;
            if (valid_m) begin
                pulses++;
                last_val = value_m;
            end
        end
        chk("busy_drop_pulses", 32'(pulses),   32'd1);
        chk("busy_drop_value",  32'(last_val), 32'h2509);

        // Back-to-back with sample_valid held high
        @(negedge clk);
        sample_in    = 8'hFF;
        sample_valid = 1'b1;
        t1 = 0;
        t2 = 0;
        e  = 0;
        while (t2 == 0 && e < 120) begin
            @(posedge clk); #1;
            e++;
            if (valid_m) begin
                if (t1 == 0) t1 = e;
                else begin
                    t2 = e;
                    sample_valid = 1'b0;
                end
            end
        end
        sample_valid = 1'b0;
        chk("b2b_first_lat", 32'(t1),      32'd37);
        chk("b2b_period",    32'(t2 - t1), 32'd37);

        // Reset during DIV aborts the conversion
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_in    = 8'h80;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("abort_busy",  32'(busy_m),  32'd0);
        chk("abort_valid", 32'(valid_m), 32'd0);
        chk("abort_value", 32'(value_m), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (valid_m) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses),  32'd0);
        chk("abort_value_after", 32'(value_m), 32'h0);
        send(8'hFF, lat);
        chk("post_abort_lat",   32'(lat),     32'd36);
        chk("post_abort_value", 32'(value_m), 32'h5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
